f_im_loader: RTL

//  Boot-time writer for the fetch-stage instruction memory. Accepts a byte stream with a

---
 rtl/f_im_loader_if.sv | 13 +
 rtl/f_im_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/f_im_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// slave = loader view, master = stream source / IM side.
interface f_im_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport slave  (input byte_in, byte_valid, output byte_ready, im_we, im_addr, im_wdata);
  modport master (output byte_in, byte_valid, input byte_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/f_im_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian byte stream -> word writes.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module f_im_loader #(
  parameter int          SIZE      = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  f_im_loader_if.slave bus,
  output logic         cpu_hold_o,
  output logic         done_o,
  output logic         error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [12:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;
`ifdef CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        ready, xfer;
  logic [15:0] n_w;
  logic [31:0] word_nx;

  assign ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
  assign xfer    = ready && bus.byte_valid;
  assign n_w     = {len_q[15:8], bus.byte_in};
  assign word_nx = {word_q[23:0], bus.byte_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
`ifdef CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
`ifdef CHECKSUM_EN
    csum_d  = csum_q;
    if (xfer && state_q != S_CHK) csum_d = csum_q ^ bus.byte_in;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef CHECKSUM_EN
          csum_d  = '0;
`endif
        end else if (state_q == S_DONE) begin
          // After a final data write, done follows the im_we cycle.
          done_d = 1'b1;
          hold_d = 1'b0;
        end
      end
      S_LEN_HI: if (xfer) begin
        len_d   = {bus.byte_in, 8'h00};
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        len_d = n_w;
        if (n_w == 16'd0) begin
`ifdef CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
`endif
        end else if (n_w > 16'(SIZE)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (xfer) begin
        word_d = word_nx;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + {17'd0, idx_q, 2'b00};
          wdata_d = word_nx;
          idx_d   = idx_q + 13'd1;
          if ({3'd0, idx_q} + 16'd1 == len_q) begin
`ifdef CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_CHK: begin
`ifdef CHECKSUM_EN
        if (xfer) begin
          if (bus.byte_in == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready = ready;
  assign bus.im_we      = we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign cpu_hold_o     = hold_q;
  assign done_o         = done_q;
  assign error_o        = err_q;

endmodule
